// File: rtl/mem_arbiter_2port_if.sv
// Bundle of both requester command/response ports plus the memory-side handshake.
interface mem_arbiter_2port_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  // Port 0 requester
  logic                  s0_valid_i;
  logic                  s0_wr_rd_i;
  logic [ADDR_WIDTH-1:0] s0_addr_i;
  logic [WIDTH-1:0]      s0_wdata_i;
  logic                  s0_ready_o;
  logic [WIDTH-1:0]      s0_rdata_o;
  logic                  s0_err_o;

  // Port 1 requester
  logic                  s1_valid_i;
  logic                  s1_wr_rd_i;
  logic [ADDR_WIDTH-1:0] s1_addr_i;
  logic [WIDTH-1:0]      s1_wdata_i;
  logic                  s1_ready_o;
  logic [WIDTH-1:0]      s1_rdata_o;
  logic                  s1_err_o;

  // Shared memory handshake
  logic                  mem_valid_o;
  logic                  mem_wr_rd_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wdata_o;
  logic                  mem_ready_i;
  logic [WIDTH-1:0]      mem_rdata_i;

  // Arbiter side
  modport slave (
    input  s0_valid_i, s0_wr_rd_i, s0_addr_i, s0_wdata_i,
    output s0_ready_o, s0_rdata_o, s0_err_o,
    input  s1_valid_i, s1_wr_rd_i, s1_addr_i, s1_wdata_i,
    output s1_ready_o, s1_rdata_o, s1_err_o,
    output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i
  );

  // Environment side: both requesters and the memory
  modport master (
    output s0_valid_i, s0_wr_rd_i, s0_addr_i, s0_wdata_i,
    input  s0_ready_o, s0_rdata_o, s0_err_o,
    output s1_valid_i, s1_wr_rd_i, s1_addr_i, s1_wdata_i,
    input  s1_ready_o, s1_rdata_o, s1_err_o,
    input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter_2port.sv
// Two-port round-robin arbiter/sequencer in front of a single-port handshake memory,
// with a watchdog that aborts accesses whose memory ready never arrives.
module mem_arbiter_2port #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_arbiter_2port_if.slave bus
);
  localparam int unsigned WDOG_W = 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic [WDOG_W-1:0]     wdog_q;
  logic [1:0]            ready_q;
  logic [1:0]            err_q;
  logic [WIDTH-1:0]      rdata0_q;
  logic [WIDTH-1:0]      rdata1_q;
  logic                  mem_valid_q;
  logic                  mem_wr_rd_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]      mem_wdata_q;
  logic                  any_req_c;
  logic                  win_c;

  // Winner selection: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    any_req_c = bus.s0_valid_i | bus.s1_valid_i;
    win_c     = 1'b0;
    if (bus.s0_valid_i && bus.s1_valid_i) begin
      win_c = ~last_grant_q;
    end else if (bus.s1_valid_i) begin
      win_c = 1'b1;
    end
  end

  // Sequencer FSM with all outputs registered; ready/err are single-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      ready_q      <= '0;
      err_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_valid_q  <= 1'b0;
      mem_wr_rd_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      case (state_q)
        IDLE: begin
          if (any_req_c) begin
            state_q      <= ISSUE;
            grant_q      <= win_c;
            last_grant_q <= win_c;
            wdog_q       <= '0;
            mem_valid_q  <= 1'b1;
            mem_wr_rd_q  <= win_c ? bus.s1_wr_rd_i : bus.s0_wr_rd_i;
            mem_addr_q   <= win_c ? bus.s1_addr_i  : bus.s0_addr_i;
            mem_wdata_q  <= win_c ? bus.s1_wdata_i : bus.s0_wdata_i;
          end
        end
        ISSUE: begin
          if (bus.mem_ready_i) begin
            state_q          <= RESP;
            mem_valid_q      <= 1'b0;
            ready_q[grant_q] <= 1'b1;
            if (!mem_wr_rd_q) begin
              if (grant_q) begin
                rdata1_q <= bus.mem_rdata_i;
              end else begin
                rdata0_q <= bus.mem_rdata_i;
              end
            end
          end else if (wdog_q == WDOG_LAST) begin
            // Memory never answered: release the port with an error, keep rdata as is.
            state_q          <= RESP;
            mem_valid_q      <= 1'b0;
            ready_q[grant_q] <= 1'b1;
            err_q[grant_q]   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.s0_ready_o  = ready_q[0];
  assign bus.s1_ready_o  = ready_q[1];
  assign bus.s0_err_o    = err_q[0];
  assign bus.s1_err_o    = err_q[1];
  assign bus.s0_rdata_o  = rdata0_q;
  assign bus.s1_rdata_o  = rdata1_q;
  assign bus.mem_valid_o = mem_valid_q;
  assign bus.mem_wr_rd_o = mem_wr_rd_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Scoreboard bench for mem_arbiter_2port: drivers push expected responses, a monitor
// pops and compares on every ready pulse; a behavioural memory answers the arbiter.
module tb_mem_arbiter_2port;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 15;

  typedef struct {
    bit           wr;
    bit           err;
    logic [W-1:0] rdata;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic stall = 1'b0;

  int checks   = 0;
  int failures = 0;

  exp_t         q0 [$];
  exp_t         q1 [$];
  int           done_q [$];
  logic [W-1:0] ref_mem [16];
  logic [W-1:0] model_rdata [2];
  logic [W-1:0] seen_rdata [2];
  logic [W-1:0] tb_mem [16];

  always #5 clk_i = ~clk_i;

  mem_arbiter_2port_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter_2port #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  assign bus.mem_rdata_i = tb_mem[bus.mem_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input bit cond, input int act);
    checks++;
    if (!cond) begin
      failures++;
      $display("FAIL %s condition false (value=%0d)", name, act);
    end
  endtask

  // Memory array: performs accepted writes.
  initial begin
    for (int i = 0; i < 16; i++) tb_mem[i] = '0;
    forever begin
      @(posedge clk_i);
      if (bus.mem_valid_o && bus.mem_ready_i && bus.mem_wr_rd_o)
        tb_mem[bus.mem_addr_o] = bus.mem_wdata_o;
    end
  end

  // Memory ready: random 0..4 cycle latency, random noise while idle, held low when stalled.
  initial begin
    int   lat;
    logic prev;
    lat  = 0;
    prev = 1'b0;
    bus.mem_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (bus.mem_valid_o && !prev) lat = $urandom_range(0, 4);
      prev = bus.mem_valid_o;
      if (stall) bus.mem_ready_i = 1'b0;
      else if (bus.mem_valid_o) begin
        if (lat == 0) bus.mem_ready_i = 1'b1;
        else begin
          lat--;
          bus.mem_ready_i = 1'b0;
        end
      end else bus.mem_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic set_port(input int p, input bit v, input bit wr,
                          input logic [AW-1:0] a, input logic [W-1:0] d);
    if (p == 0) begin
      bus.s0_valid_i = v; bus.s0_wr_rd_i = wr; bus.s0_addr_i = a; bus.s0_wdata_i = d;
    end else begin
      bus.s1_valid_i = v; bus.s1_wr_rd_i = wr; bus.s1_addr_i = a; bus.s1_wdata_i = d;
    end
  endtask

  // Reference model: a plain memory array plus each port's last read result.
  task automatic push_exp(input int p, input bit wr, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input bit err);
    exp_t e;
    e.wr  = wr;
    e.err = err;
    if (!err && wr) ref_mem[a] = d;
    else if (!err) model_rdata[p] = ref_mem[a];
    e.rdata = model_rdata[p];
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_ready(input int p);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 80) begin
      @(negedge clk_i);
      n++;
      got = (p == 0) ? bus.s0_ready_o : bus.s1_ready_o;
    end
    check_true($sformatf("ready_bound_p%0d", p), got, n);
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic issue(input int p, input bit wr, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input bit chk_mem);
    bit got;
    set_port(p, 1'b1, wr, a, d);
    push_exp(p, wr, a, d, 1'b0);
    if (chk_mem) begin
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
        @(negedge clk_i);
        got = bus.mem_valid_o;
      end
      check_true("mem_valid_seen", got, 0);
      check("mem_addr", 32'(bus.mem_addr_o), 32'(a));
      check("mem_wr_rd", 32'(bus.mem_wr_rd_o), 32'(wr));
      if (wr) check("mem_wdata", 32'(bus.mem_wdata_o), 32'(d));
    end
    wait_ready(p);
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      bit           wr;
      logic [AW-1:0] a;
      logic [W-1:0]  d;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      wr = 1'($urandom_range(0, 1));
      a  = AW'(p * 8 + int'($urandom_range(0, 7)));
      d  = W'($urandom);
      issue(p, wr, a, d, 1'b0);
    end
  endtask

  // Monitor: pops one expectation per ready pulse, checks rdata/err, cross-port hold and fairness.
  initial begin
    logic         r [2];
    logic         e [2];
    logic         v [2];
    logic [W-1:0] rd [2];
    int           foreign [2];
    exp_t         x;
    foreign[0] = 0;
    foreign[1] = 0;
    forever begin
      @(posedge clk_i);
      #1;
      r[0] = bus.s0_ready_o; r[1] = bus.s1_ready_o;
      e[0] = bus.s0_err_o;   e[1] = bus.s1_err_o;
      v[0] = bus.s0_valid_i; v[1] = bus.s1_valid_i;
      rd[0] = bus.s0_rdata_o; rd[1] = bus.s1_rdata_o;
      if (rst_i) begin
        seen_rdata[0] = '0; seen_rdata[1] = '0;
        foreign[0] = 0; foreign[1] = 0;
      end else begin
        if (r[0] || r[1]) check("single_ready", 32'({r[0], r[1]} == 2'b11), 32'd0);
        for (int p = 0; p < 2; p++) begin
          if (e[p] && !r[p]) check_true($sformatf("err_without_ready_p%0d", p), 1'b0, p);
          if (r[1-p] && v[p]) foreign[p]++;
          if (r[p]) begin
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
              check_true($sformatf("unexpected_ready_p%0d", p), 1'b0, p);
            end else begin
              if (p == 0) x = q0.pop_front();
              else x = q1.pop_front();
              check($sformatf("err_p%0d", p), 32'(e[p]), 32'(x.err));
              check($sformatf("rdata_p%0d", p), 32'(rd[p]), 32'(x.rdata));
              seen_rdata[p] = x.rdata;
            end
            check($sformatf("rdata_hold_p%0d", 1-p), 32'(rd[1-p]), 32'(seen_rdata[1-p]));
            check_true($sformatf("fair_wait_p%0d", p), foreign[p] <= 1, foreign[p]);
            foreign[p] = 0;
            done_q.push_back(p);
          end
        end
      end
    end
  end

  initial begin
    bit got;
    int cnt;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    model_rdata[0] = '0; model_rdata[1] = '0;
    seen_rdata[0]  = '0; seen_rdata[1]  = '0;

    // Reset with both requests pending; first grant must go to port 0.
    rst_i = 1'b1;
    set_port(0, 1'b1, 1'b1, 4'd0, 16'h1111);
    set_port(1, 1'b1, 1'b1, 4'd8, 16'h2222);
    push_exp(0, 1'b1, 4'd0, 16'h1111, 1'b0);
    push_exp(1, 1'b1, 4'd8, 16'h2222, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check("rst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
      check("rst_ready", 32'({bus.s0_ready_o, bus.s1_ready_o, bus.s0_err_o, bus.s1_err_o}), 32'd0);
      check("rst_rdata", 32'({bus.s0_rdata_o, bus.s1_rdata_o}), 32'd0);
      check("rst_mem_bus", 32'({bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o}), 32'd0);
    end
    rst_i = 1'b0;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 40) begin
      @(negedge clk_i);
      cnt++;
      got = bus.s0_ready_o | bus.s1_ready_o;
    end
    check_true("first_grant_seen", got, cnt);
    check("first_grant_port", 32'({bus.s0_ready_o, bus.s1_ready_o}), 32'b10);
    set_port(0, 1'b0, 1'b0, '0, '0);
    wait_ready(1);

    // Single port write then read of address 3.
    issue(0, 1'b1, 4'd3, 16'hA5A5, 1'b1);
    issue(0, 1'b0, 4'd3, 16'h0000, 1'b1);

    // Cross-port read: port 1 reads what port 0 wrote.
    issue(0, 1'b1, 4'd2, 16'h1234, 1'b0);
    issue(1, 1'b0, 4'd2, 16'h0000, 1'b0);

    // Watchdog: memory never answers.
    stall = 1'b1;
    set_port(0, 1'b1, 1'b0, 4'd3, '0);
    push_exp(0, 1'b0, 4'd3, '0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk_i);
      got = bus.mem_valid_o;
    end
    check_true("timeout_valid_rise", got, 0);
    cnt = 1;
    got = 1'b0;
    while (!got && cnt < 40) begin
      @(negedge clk_i);
      cnt++;
      got = bus.s0_ready_o;
    end
    check("timeout_cycles", 32'(cnt), 32'(TO + 1));
    check("timeout_err", 32'(bus.s0_err_o), 32'd1);
    check("timeout_mem_valid", 32'(bus.mem_valid_o), 32'd0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    stall = 1'b0;
    issue(0, 1'b0, 4'd2, '0, 1'b1);

    // Contention: both ports stream writes, completions must alternate.
    done_q.delete();
    fork
      for (int i = 0; i < 4; i++) issue(0, 1'b1, AW'(1 + i), W'(16'h0100 + i), 1'b0);
      for (int i = 0; i < 4; i++) issue(1, 1'b1, AW'(9 + i), W'(16'h0900 + i), 1'b0);
    join
    check("contention_count", 32'(done_q.size()), 32'd8);
    for (int i = 1; i < done_q.size(); i++)
      check("contention_alternate", 32'(done_q[i] == done_q[i-1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, AW'(1 + i), '0, 1'b0);
      issue(1, 1'b0, AW'(9 + i), '0, 1'b0);
    end

    // Randomized traffic on disjoint address halves.
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join

    // Reset while an access is stuck in ISSUE: dropped with no ready pulse.
    stall = 1'b1;
    set_port(1, 1'b1, 1'b0, 4'd5, '0);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk_i);
      got = bus.mem_valid_o;
    end
    check_true("midrst_valid_rise", got, 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
    check("midrst_ready", 32'({bus.s0_ready_o, bus.s1_ready_o, bus.s1_err_o}), 32'd0);
    check("midrst_rdata", 32'({bus.s0_rdata_o, bus.s1_rdata_o}), 32'd0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    rst_i = 1'b0;
    stall = 1'b0;
    model_rdata[0] = '0; model_rdata[1] = '0;
    issue(1, 1'b0, 4'd9, '0, 1'b1);
    issue(0, 1'b0, 4'd3, '0, 1'b1);

    repeat (4) @(negedge clk_i);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_2port.md
# mem_arbiter_2port

Two-requester arbiter and sequencer for the shared single-port handshake memory: accepts valid/ready commands from two independent masters (port 0, port 1), grants the memory to one at a time under round-robin priority, drives the memory's addr/wdata/wr_rd/valid interface, and returns ready plus read data to the winner. It sits directly in front of the memory instance; the memory is unchanged. A watchdog aborts any access whose memory ready never arrives.

## Interface
- WIDTH, 16, data width
- ADDR_WIDTH, 4, address width
- TIMEOUT, 15, max cycles mem_valid_o may wait for mem_ready_i (1..255)

- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  reset, synchronous, active-high
- s0_valid_i, s1_valid_i  in  1  request from port 0 / 1
- s0_wr_rd_i, s1_wr_rd_i  in  1  1 = write, 0 = read
- s0_addr_i, s1_addr_i  in  ADDR_WIDTH  address
- s0_wdata_i, s1_wdata_i  in  WIDTH  write data
- s0_ready_o, s1_ready_o  out  1  one-cycle completion pulse
- s0_rdata_o, s1_rdata_o  out  WIDTH  read data, registered, held until that port's next read completes
- s0_err_o, s1_err_o  out  1  pulses with ready when the access timed out
- mem_valid_o  out  1  request to memory
- mem_wr_rd_o  out  1  to memory wr_rd
- mem_addr_o  out  ADDR_WIDTH  to memory addr
- mem_wdata_o  out  WIDTH  to memory wdata
- mem_ready_i  in  1  memory ready
- mem_rdata_i  in  WIDTH  memory read data, valid in cycle mem_ready_i=1

## Operation
- Requester rule: hold valid, wr_rd, addr, wdata stable from assertion until the edge where its ready_o=1.
- FSM states IDLE, ISSUE, RESP.
- IDLE: if any valid, pick winner, latch its command into mem_* registers, set grant, go ISSUE. No request: stay.
- Arbitration: one requester -> it wins. Both -> port not in last_grant wins. last_grant updates when a grant is issued. Reset: last_grant=1, so port 0 wins first tie.
- ISSUE: mem_valid_o=1, mem_* stable. On edge with mem_ready_i=1: capture mem_rdata_i into granted port's rdata register if read, go RESP. Watchdog counts ISSUE cycles; when it reaches TIMEOUT without ready: set err flag, go RESP, rdata register unchanged.
- RESP: granted port's ready_o=1 (err_o=1 if timeout), mem_valid_o=0, other port's ready_o=0. Always returns to IDLE next edge; valids seen in RESP are ignored.
- Write data and rdata never cross ports; a write does not alter either rdata register.
- rst_i mid-transaction: next edge forces IDLE, all outputs to reset values, in-flight access dropped with no ready pulse.

## Timing
- Reset values: s*_ready_o=0, s*_err_o=0, s*_rdata_o=0, mem_valid_o=0, mem_wr_rd_o=0, mem_addr_o=0, mem_wdata_o=0, watchdog=0, last_grant=1.
- All outputs registered; no combinational input-to-output path.
- Request sampled at edge N in IDLE -> mem_valid_o high from N+1. mem_ready_i sampled high at edge M -> mem_valid_o low and ready_o high in cycle M..M+1. Minimum occupancy 3 cycles per access (memory ready immediately).
- Back-to-back: next grant sampled at the edge leaving RESP+1 (IDLE), i.e. one IDLE cycle between accesses.
- Timeout: ready_o/err_o pulse in the cycle after the TIMEOUT-th ISSUE cycle.
- mem_ready_i outside ISSUE is ignored.

## Test plan
- Reset: hold rst_i 2 cycles with both valids high -> all outputs 0, no mem_valid_o; first grant after release to port 0.
- Single port: port 0 writes 0xA5A5 to addr 3, then reads addr 3 -> mem_addr_o=3, mem_wr_rd_o=1 then 0; s0_rdata_o=0xA5A5 with s0_ready_o pulse; s1 outputs idle.
- Contention: both ports hold valid continuously, port 0 writes addr 1..4, port 1 writes addr 9..12 -> grants alternate 0,1,0,1..., all eight words land, no port waits more than one foreign access.
- Cross-read: port 1 reads addr 2 written by port 0 (0x1234) -> s1_rdata_o=0x1234, s0_rdata_o unchanged.
- Timeout: memory model holds mem_ready_i=0, TIMEOUT=15 -> s0_ready_o and s0_err_o pulse exactly 16 cycles after mem_valid_o rose, s0_rdata_o unchanged, next request serviced normally.
- Reset mid-ISSUE: assert rst_i while mem_valid_o=1 -> mem_valid_o=0 next cycle, no ready pulse, FSM IDLE.
